lcd_init_sequencer: RTL and testbench
=====================================

// Module: lcd_init_sequencer
// PURPOSE
//  Power-on/re-init command sequencer for the HD44780-style character LCD. Sits downstream
//  of clock_divider: counts its 1 ms tick to enforce controller timing, then issues the fixed
//  init command list to the LCD byte writer over a valid/ready command interface. Raises
//  init_done when the display is ready for message traffic.
// PARAMETERS
//  AUTO_START      1      1: sequence starts automatically after reset; 0: waits for start
//  POWERUP_MS      40     power-on settle time before the first command (ms)
//  FS1_DELAY_MS    5      wait after the first function-set (ms)
//  CMD_DELAY_MS    1      wait after ordinary commands (ms)
//  CLEAR_DELAY_MS  2      wait after clear-display (ms)
//  FUNC_SET        8'h38  function-set byte (8-bit bus, 2 lines, 5x8 font)
//  TIMEOUT_MS      100    max ms cmd_valid may wait for cmd_ready before error
// PORTS
//  clk_50m    in   1  50 MHz system clock (only clock)
//  reset      in   1  synchronous, active-high reset
//  tick_1ms   in   1  1-cycle pulse every 1 ms from clock_divider
//  start      in   1  1-cycle request to (re)run the init sequence
//  cmd_ready  in   1  LCD byte writer can accept a command this cycle
//  cmd_valid  out  1  command byte on cmd_data is valid
//  cmd_data   out  8  command byte
//  cmd_rs     out  1  register select; always 0 (instruction register)
//  busy       out  1  sequence in progress
//  init_done  out  1  sequence completed successfully; held until next start/reset
//  init_err   out  1  cmd_ready timeout occurred; held until next start/reset
//  step       out  3  index of current/last command (0..5)
// BEHAVIOUR
//  Reset (sync, wins over all inputs): cmd_valid=0, cmd_data=8'h00, cmd_rs=0, busy=0,
//   init_done=0, init_err=0, step=0, all counters 0, state=IDLE. Reset mid-operation aborts
//   immediately; cmd_valid is 0 the cycle after reset is sampled.
//  Command list (step: byte / post-delay): 0: FUNC_SET/FS1_DELAY_MS, 1: FUNC_SET/CMD_DELAY_MS,
//   2: FUNC_SET/CMD_DELAY_MS, 3: 8'h0C/CMD_DELAY_MS, 4: 8'h01/CLEAR_DELAY_MS,
//   5: 8'h06/CMD_DELAY_MS.
//  States: IDLE -> PWR_WAIT -> SEND <-> WAIT -> DONE; ERROR.
//   IDLE: leaves to PWR_WAIT on first cycle after reset if AUTO_START=1, else on start.
//   PWR_WAIT: busy=1; delay counter loaded POWERUP_MS+1, decremented per tick_1ms; -> SEND
//    when it reaches 0 (guarantees >= POWERUP_MS ms regardless of tick phase).
//   SEND: cmd_valid=1 with cmd_data=ROM[step]; cmd_data/step stable while cmd_ready=0.
//    Accept = cmd_valid & cmd_ready; on accept -> WAIT, cmd_valid=0 next cycle, delay
//    counter loaded ROM delay+1. A tick_1ms in the accept cycle is not counted.
//    Timeout counter counts tick_1ms while in SEND; reaching TIMEOUT_MS+1 ticks without
//    accept -> ERROR (cmd_valid=0, busy=0, init_err=1). Cleared on every entry to SEND.
//   WAIT: decrement on tick_1ms; at 0: step<5 -> step+1, SEND; step==5 -> DONE.
//   DONE: busy=0, init_done=1.  ERROR: busy=0, init_err=1.
//  start: ignored while busy=1. In DONE/ERROR: next cycle clears init_done/init_err,
//   step=0, busy=1, enters SEND directly (no power-up wait). In IDLE with AUTO_START=0:
//   enters PWR_WAIT.
//  Latency: cmd_valid rises the cycle after entering SEND. Delay counters 8 bits, timeout
//   counter $clog2(TIMEOUT_MS+2) bits; no wrap (saturating terminal compare).
// STRUCTURE
//  lcd_pkg: state encoding localparams, LCD command constants (CLEAR, ENTRY_INC,
//   DISP_ON, FUNC_SET_8B2L), NUM_INIT_CMDS=6.
//  Sub-module lcd_init_rom: combinational step -> {cmd byte, delay ms}; top holds the FSM,
//   delay counter and timeout counter.
// TESTING (tick_1ms driven by bench every 10 cycles unless noted)
//  1 AUTO_START=1, cmd_ready=1 -> first cmd_valid after 41 ticks; accepted bytes 38,38,38,
//    0C,01,06 in order; init_done=1 after final 2-tick wait; busy=0.
//  2 cmd_ready=0 for 50 cycles at step 3 -> cmd_valid=1, cmd_data=8'h0C, step=3 stable; then
//    ready=1 -> single accept, sequence resumes.
//  3 cmd_ready stuck 0 -> after 101 ticks in SEND: init_err=1, cmd_valid=0, busy=0; start ->
//    init_err=0, cmd_valid=1 with 8'h38 next cycle.
//  4 reset asserted during WAIT at step 4 -> next cycle all outputs at reset values; on
//    release full sequence incl. 41-tick power-up wait repeats.
//  5 start pulsed while busy -> no effect; start in DONE -> init_done=0 next cycle, sequence
//    re-runs from step 0 without power-up wait.
//  6 tick_1ms coincident with accept of step 5 -> delay still requires 2 further ticks
//    before init_done=1.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the HD44780-style LCD init sequencer.
//                Holds the sequencer state encoding, the LCD instruction
//                constants used by the init list and the list length.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Number of commands in the power-on init list and the index of the last one
  localparam int           NUM_INIT_CMDS = 6;
  localparam int           STEP_W        = 3;
  localparam logic [2:0]   LAST_STEP     = 3'(NUM_INIT_CMDS - 1);

  // Millisecond delay counters are 8 bits wide
  localparam int           DLY_W         = 8;

  // HD44780 instruction bytes used by the init list
  localparam logic [7:0]   CMD_CLEAR         = 8'h01;  // clear display, cursor home
  localparam logic [7:0]   CMD_ENTRY_INC     = 8'h06;  // increment address, no shift
  localparam logic [7:0]   CMD_DISP_ON       = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0]   CMD_FUNC_SET_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font

  // Sequencer state encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT     = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_init_rom.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_init_rom
//  Description : Combinational lookup of the LCD init command list.
//                Maps a step index to the instruction byte to send and the
//                settle time (ms) the controller needs after it.
//  Ports       : step_i      - command index (0..5); other values return 0/0
//                cmd_o       - instruction byte for that step
//                delay_ms_o  - post-command settle time in ms
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter logic [7:0] FUNC_SET       = CMD_FUNC_SET_8B2L,
  parameter int         FS1_DELAY_MS   = 5,
  parameter int         CMD_DELAY_MS   = 1,
  parameter int         CLEAR_DELAY_MS = 2
) (
  input  logic [STEP_W-1:0] step_i,
  output logic [7:0]        cmd_o,
  output logic [DLY_W-1:0]  delay_ms_o
);

  always_comb begin
    cmd_o      = 8'h00;
    delay_ms_o = '0;
    case (step_i)
      // The first function-set is issued while the controller may still be
      // in its own reset; it needs the long wait before the repeats.
      3'd0: begin cmd_o = FUNC_SET;      delay_ms_o = DLY_W'(FS1_DELAY_MS);   end
      3'd1: begin cmd_o = FUNC_SET;      delay_ms_o = DLY_W'(CMD_DELAY_MS);   end
      3'd2: begin cmd_o = FUNC_SET;      delay_ms_o = DLY_W'(CMD_DELAY_MS);   end
      3'd3: begin cmd_o = CMD_DISP_ON;   delay_ms_o = DLY_W'(CMD_DELAY_MS);   end
      3'd4: begin cmd_o = CMD_CLEAR;     delay_ms_o = DLY_W'(CLEAR_DELAY_MS); end
      3'd5: begin cmd_o = CMD_ENTRY_INC; delay_ms_o = DLY_W'(CMD_DELAY_MS);   end
      default: begin cmd_o = 8'h00;      delay_ms_o = '0;                     end
    endcase
  end

endmodule : lcd_init_rom
`default_nettype wire

// File: rtl/lcd_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_init_sequencer
//  Description : Power-on / re-init command sequencer for an HD44780-style
//                character LCD. Counts the 1 ms tick to honour controller
//                timing and hands the fixed init list to the LCD byte writer
//                over a valid/ready interface. Flags completion or a
//                cmd_ready timeout.
//  Ports       : clk_50m_i    - 50 MHz system clock
//                reset_i      - synchronous active-high reset
//                tick_1ms_i   - 1-cycle pulse every millisecond
//                start_i      - 1-cycle request to (re)run the sequence
//                cmd_ready_i  - byte writer can accept a command
//                cmd_valid_o  - cmd_data_o holds a command to send
//                cmd_data_o   - instruction byte
//                cmd_rs_o     - register select, always instruction (0)
//                busy_o       - sequence in progress
//                init_done_o  - sequence completed (sticky until start/reset)
//                init_err_o   - cmd_ready timeout (sticky until start/reset)
//                step_o       - index of current/last command
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter bit         AUTO_START     = 1'b1,
  parameter int         POWERUP_MS     = 40,
  parameter int         FS1_DELAY_MS   = 5,
  parameter int         CMD_DELAY_MS   = 1,
  parameter int         CLEAR_DELAY_MS = 2,
  parameter logic [7:0] FUNC_SET       = CMD_FUNC_SET_8B2L,
  parameter int         TIMEOUT_MS     = 100
) (
  input  logic              clk_50m_i,
  input  logic              reset_i,
  input  logic              tick_1ms_i,
  input  logic              start_i,
  input  logic              cmd_ready_i,
  output logic              cmd_valid_o,
  output logic [7:0]        cmd_data_o,
  output logic              cmd_rs_o,
  output logic              busy_o,
  output logic              init_done_o,
  output logic              init_err_o,
  output logic [STEP_W-1:0] step_o
);

  localparam int               TMO_W     = $clog2(TIMEOUT_MS + 2);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_MS);
  // One extra tick absorbs an arbitrary phase between entry and the first tick
  localparam logic [DLY_W-1:0] PWR_LOAD  = DLY_W'(POWERUP_MS + 1);

  state_e              state_q;
  logic [DLY_W-1:0]    dly_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [STEP_W-1:0]   step_q;
  logic                cmd_valid_q;
  logic [7:0]          cmd_data_q;
  logic                busy_q;
  logic                init_done_q;
  logic                init_err_q;

  logic [STEP_W-1:0]   w_rom_addr;
  logic [7:0]          w_rom_cmd;
  logic [DLY_W-1:0]    w_rom_dly;
  logic                w_accept;
  logic                w_dly_expire;

  // The ROM is shared: in SEND it supplies the delay of the command being
  // accepted; in WAIT it looks ahead to the next byte so the byte can be
  // registered on the same edge that re-enters SEND; elsewhere it points at
  // step 0 for a fresh start.
  always_comb begin
    w_rom_addr = '0;
    case (state_q)
      ST_SEND: w_rom_addr = step_q;
      ST_WAIT: w_rom_addr = step_q + 3'd1;
      default: w_rom_addr = '0;
    endcase
  end

  lcd_init_rom #(
    .FUNC_SET       (FUNC_SET),
    .FS1_DELAY_MS   (FS1_DELAY_MS),
    .CMD_DELAY_MS   (CMD_DELAY_MS),
    .CLEAR_DELAY_MS (CLEAR_DELAY_MS)
  ) u_rom (
    .step_i     (w_rom_addr),
    .cmd_o      (w_rom_cmd),
    .delay_ms_o (w_rom_dly)
  );

  assign w_accept     = cmd_valid_q & cmd_ready_i;
  // Terminal compare at 1 so the counter saturates instead of wrapping
  assign w_dly_expire = tick_1ms_i & (dly_q <= 8'd1);

  always_ff @(posedge clk_50m_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      tmo_q       <= '0;
      step_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (AUTO_START || start_i) begin
            state_q <= ST_PWR_WAIT;
            busy_q  <= 1'b1;
            dly_q   <= PWR_LOAD;
          end
        end

        ST_PWR_WAIT: begin
          if (w_dly_expire) begin
            state_q     <= ST_SEND;
            dly_q       <= '0;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= w_rom_cmd;
          end else if (tick_1ms_i) begin
            dly_q <= dly_q - 8'd1;
          end
        end

        ST_SEND: begin
          if (w_accept) begin
            // A tick coinciding with the accept is deliberately dropped:
            // the full delay+1 ticks are counted from the next cycle on.
            state_q     <= ST_WAIT;
            cmd_valid_q <= 1'b0;
            dly_q       <= w_rom_dly + 8'd1;
          end else if (tick_1ms_i) begin
            if (tmo_q >= TMO_LIMIT) begin
              state_q     <= ST_ERROR;
              cmd_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              init_err_q  <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (w_dly_expire) begin
            dly_q <= '0;
            if (step_q == LAST_STEP) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              init_done_q <= 1'b1;
            end else begin
              state_q     <= ST_SEND;
              step_q      <= step_q + 3'd1;
              tmo_q       <= '0;
              cmd_valid_q <= 1'b1;
              cmd_data_q  <= w_rom_cmd;
            end
          end else if (tick_1ms_i) begin
            dly_q <= dly_q - 8'd1;
          end
        end

        ST_DONE, ST_ERROR: begin
          // Re-init skips the power-up wait: the controller is already alive
          if (start_i) begin
            state_q     <= ST_SEND;
            step_q      <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= w_rom_cmd;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cmd_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_data_o  = cmd_data_q;
  assign cmd_rs_o    = 1'b0;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;
  assign init_err_o  = init_err_q;
  assign step_o      = step_q;

endmodule : lcd_init_sequencer
`default_nettype wire

// File: tb/tb_lcd_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_init_sequencer
//  Description : Self-checking bench for lcd_init_sequencer. Drives a 1 ms
//                tick every 10 cycles, randomised cmd_ready back-pressure and
//                stray start pulses, and checks command order, tick-accurate
//                delays, timeout, restart and reset behaviour against the
//                command list and timing rules held in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_init_sequencer;

  localparam int TICK_DIV   = 10;
  localparam int POWERUP_MS = 40;
  localparam int TIMEOUT_MS = 100;

  logic       clk = 1'b0;
  logic       reset, tick, start, cmd_ready;
  logic       cmd_valid, cmd_rs, busy, init_done, init_err;
  logic [7:0] cmd_data;
  logic [2:0] step;

  logic       start0;
  logic       ready0 = 1'b1;
  logic       cmd_valid0, cmd_rs0, busy0, init_done0, init_err0;
  logic [7:0] cmd_data0;
  logic [2:0] step0;

  int checks = 0;
  int errors = 0;
  int tick_ph = 0;
  bit edge_tick = 1'b0;

  // Init list as the LCD controller expects it: byte and settle time in ms
  logic [7:0] exp_b [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         exp_d [6] = '{5, 1, 1, 1, 2, 1};

  always #5 clk = ~clk;

  lcd_init_sequencer #(.AUTO_START(1'b1)) dut (
    .clk_50m_i(clk), .reset_i(reset), .tick_1ms_i(tick), .start_i(start),
    .cmd_ready_i(cmd_ready), .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data),
    .cmd_rs_o(cmd_rs), .busy_o(busy), .init_done_o(init_done),
    .init_err_o(init_err), .step_o(step)
  );

  lcd_init_sequencer #(.AUTO_START(1'b0)) dut0 (
    .clk_50m_i(clk), .reset_i(reset), .tick_1ms_i(tick), .start_i(start0),
    .cmd_ready_i(ready0), .cmd_valid_o(cmd_valid0), .cmd_data_o(cmd_data0),
    .cmd_rs_o(cmd_rs0), .busy_o(busy0), .init_done_o(init_done0),
    .init_err_o(init_err0), .step_o(step0)
  );

  // Apply inputs for the coming rising edge, then return at the following
  // falling edge with edge_tick = tick value that edge sampled.
  task automatic step_clk(input bit rdy, input bit st);
    cmd_ready = rdy;
    start     = st;
    tick      = (tick_ph == TICK_DIV - 1);
    tick_ph   = (tick_ph == TICK_DIV - 1) ? 0 : tick_ph + 1;
    @(negedge clk);
    edge_tick = tick;
  endtask

  // Runs one full init sequence from either reset release (pwr=1) or a
  // start pulse in DONE/ERROR (pwr=0). Optional: hold ready low 50 cycles
  // at step hold_k, align the final accept with a tick, abort by reset once
  // abort_k commands were accepted, inject stray start pulses.
  task automatic run_seq(input bit pwr, input int pct, input bit sync5,
                         input int hold_k, input int abort_k, input bit rnd_start);
    int k = 0;
    int tk = 0;
    int held = 0;
    bit was_valid = 1'b0;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    bit acc, rdy, st;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (abort_k >= 0 && k == abort_k) begin
        reset = 1'b1;
        step_clk(1'b0, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, cmd_rs, busy, init_done, init_err, step} !== 16'h0) begin
          errors++;
          $display("FAIL abort_reset: outputs %h, want 0000",
                   {cmd_valid, cmd_data, cmd_rs, busy, init_done, init_err, step});
        end
        aborted = 1'b1;
        break;
      end
      if (cmd_valid && k == hold_k && held < 50) begin
        rdy = 1'b0;
        held++;
      end else if (cmd_valid && sync5 && k == 5) begin
        rdy = (tick_ph == TICK_DIV - 1);
      end else begin
        rdy = ($urandom_range(0, 99) < pct);
      end
      acc = cmd_valid && rdy;
      if (pwr) st = (cyc > 0) && rnd_start && ($urandom_range(0, 15) == 0);
      else     st = (cyc == 0) || (rnd_start && ($urandom_range(0, 15) == 0));
      step_clk(rdy, st);
      if (acc) begin
        k++;
        tk = 0;
      end else if (!(pwr && cyc == 0)) begin
        tk += int'(edge_tick);
      end

      if (acc && k < 6) begin
        checks++;
        if (cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop: cmd_valid=%b after accept of step %0d, want 0", cmd_valid, k-1);
        end
      end
      if (cmd_valid && !was_valid) begin
        checks++;
        if (k == 0 && !pwr) begin
          if (cyc != 0) begin
            errors++;
            $display("FAIL start_latency: cmd_valid rose %0d cycles after start, want 1", cyc+1);
          end
        end else if (k == 0) begin
          if (tk != POWERUP_MS + 1 || !edge_tick) begin
            errors++;
            $display("FAIL pwr_ticks: valid after %0d ticks (last edge tick=%b), want %0d/1",
                     tk, edge_tick, POWERUP_MS + 1);
          end
        end else if (k < 6) begin
          if (tk != exp_d[k-1] + 1 || !edge_tick) begin
            errors++;
            $display("FAIL cmd_delay: step %0d valid after %0d ticks (last edge tick=%b), want %0d/1",
                     k, tk, edge_tick, exp_d[k-1] + 1);
          end
        end
      end
      if (cmd_valid) begin
        checks++;
        if (k >= 6) begin
          errors++;
          $display("FAIL extra_cmd: cmd_valid=1 data=%h after all 6 accepts", cmd_data);
        end else if (cmd_data !== exp_b[k] || step !== 3'(k) || cmd_rs !== 1'b0) begin
          errors++;
          $display("FAIL cmd_word: data=%h step=%0d rs=%b, want data=%h step=%0d rs=0",
                   cmd_data, step, cmd_rs, exp_b[k], k);
        end
      end
      if (k == 6 && init_done) begin
        checks++;
        if (tk != 2 || !edge_tick || busy !== 1'b0 || cmd_valid !== 1'b0 || step !== 3'd5) begin
          errors++;
          $display("FAIL done_state: ticks=%0d tick=%b busy=%b valid=%b step=%0d, want 2/1/0/0/5",
                   tk, edge_tick, busy, cmd_valid, step);
        end
        finished = 1'b1;
        break;
      end else begin
        checks++;
        if (busy !== 1'b1 || init_done !== 1'b0 || init_err !== 1'b0) begin
          errors++;
          $display("FAIL run_status: busy=%b done=%b err=%b at step %0d, want 1/0/0",
                   busy, init_done, init_err, k);
        end
      end
      was_valid = cmd_valid;
    end
    if (!finished && !aborted) begin
      errors++;
      $display("FAIL seq_timeout: sequence stuck after %0d accepts", k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step_clk(1'($urandom_range(0, 1)), 1'b1);
    start0 = 1'b1;
    step_clk(1'b1, 1'b1);
    start0 = 1'b0;
    checks++;
    if ({cmd_valid, cmd_data, cmd_rs, busy, init_done, init_err, step} !== 16'h0) begin
      errors++;
      $display("FAIL reset_vals: outputs %h, want 0000",
               {cmd_valid, cmd_data, cmd_rs, busy, init_done, init_err, step});
    end
    checks++;
    if ({cmd_valid0, cmd_data0, cmd_rs0, busy0, init_done0, init_err0, step0} !== 16'h0) begin
      errors++;
      $display("FAIL reset_vals_manual: outputs %h, want 0000",
               {cmd_valid0, cmd_data0, cmd_rs0, busy0, init_done0, init_err0, step0});
    end
  endtask

  task automatic test_manual_start();
    int tk = 0;
    bit seen = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_clk(1'b0, 1'b0);
      checks++;
      if (busy0 !== 1'b0 || cmd_valid0 !== 1'b0) begin
        errors++;
        $display("FAIL manual_idle: busy=%b valid=%b without start, want 0/0", busy0, cmd_valid0);
      end
    end
    start0 = 1'b1;
    step_clk(1'b0, 1'b0);
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL manual_busy: busy=%b after start, want 1", busy0);
    end
    for (int i = 0; i < 700; i++) begin
      step_clk(1'b0, 1'b0);
      tk += int'(edge_tick);
      if (cmd_valid0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || tk != POWERUP_MS + 1 || !edge_tick || cmd_data0 !== 8'h38) begin
      errors++;
      $display("FAIL manual_pwr: seen=%b ticks=%0d data=%h, want 1/%0d/38",
               seen, tk, cmd_data0, POWERUP_MS + 1);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step_clk(1'b0, 1'b0);
  endtask

  task automatic test_auto_sequence();
    reset = 1'b0;
    run_seq(1'b1, 100, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_back_pressure();
    run_seq(1'b0, 60, 1'b0, 3, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_seq(1'b0, 75, 1'b0, -1, -1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step_clk(1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (init_done !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: done=%b busy=%b valid=%b, want 1/0/0", init_done, busy, cmd_valid);
      end
    end
  endtask

  task automatic test_tick_on_final_accept();
    run_seq(1'b0, 70, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_timeout();
    int tk = 0;
    bit seen = 1'b0;
    step_clk(1'b0, 1'b1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h38 || step !== 3'd0 || busy !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL restart: valid=%b data=%h step=%0d busy=%b done=%b, want 1/38/0/1/0",
               cmd_valid, cmd_data, step, busy, init_done);
    end
    for (int i = 0; i < 1300; i++) begin
      step_clk(1'b0, 1'b0);
      tk += int'(edge_tick);
      if (init_err) begin
        seen = 1'b1;
        break;
      end
      if (cmd_valid !== 1'b1 || busy !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL timeout_wait: valid=%b busy=%b after %0d ticks, want 1/1", cmd_valid, busy, tk);
      end
    end
    checks++;
    if (!seen || tk != TIMEOUT_MS + 1 || !edge_tick || cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: seen=%b ticks=%0d valid=%b busy=%b, want 1/%0d/0/0",
               seen, tk, cmd_valid, busy, TIMEOUT_MS + 1);
    end
    for (int i = 0; i < 15; i++) begin
      step_clk(1'b1, 1'b0);
      checks++;
      if (init_err !== 1'b1 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL err_hold: err=%b valid=%b, want 1/0", init_err, cmd_valid);
      end
    end
    run_seq(1'b0, 80, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    run_seq(1'b0, 90, 1'b0, -1, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_clk(1'b1, 1'b1);
      checks++;
      if ({cmd_valid, busy, init_done, init_err, step} !== 7'h0) begin
        errors++;
        $display("FAIL reset_hold: valid=%b busy=%b done=%b err=%b step=%0d, want all 0",
                 cmd_valid, busy, init_done, init_err, step);
      end
    end
    reset = 1'b0;
    run_seq(1'b1, 80, 1'b0, -1, -1, 1'b1);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; cmd_ready = 1'b0; start0 = 1'b0;
    test_reset();
    test_manual_start();
    test_auto_sequence();
    test_back_pressure();
    test_start_while_busy();
    test_tick_on_final_accept();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lcd_init_sequencer
`default_nettype wire
